freq_counter_latch: RTL and testbench

FREQ_COUNTER_LATCH -- requirements
Module: freq_counter_latch

---
 rtl/freq_counter_latch.sv | 149 ++++++++++++++
 tb/tb_freq_counter_latch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_latch.sv
// Gated BCD frequency counter with a synchronized control interface and a result latch.
// Optional FREQ_OVF_SATURATE_EN: saturate at all-9s and flag ovf; otherwise the count wraps and ovf is 0.
module freq_counter_latch #(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sig_in,
    input  logic                count_en,
    input  logic                latch_en,
    input  logic                clear,
    output logic [4*DIGITS-1:0] freq_bcd,
    output logic                freq_valid,
    output logic                ovf
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COUNT   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_LATCHED = 2'd3;

    logic [SYNC_STAGES-1:0] sig_sync;
    logic [SYNC_STAGES-1:0] gate_sync;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clear_sync;
    logic                   sig_d;
    logic                   latch_d;
    logic                   clear_d;
    logic                   edge_p;
    logic                   latch_p;
    logic                   clear_p;
    logic                   gate;

    logic [1:0]             state;
    logic [W-1:0]           count;
    logic [W-1:0]           count_inc;
    logic                   inc_req;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Pulses are registered so edge_p lands SYNC_STAGES+1 clk after the pin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_sync   <= '0;
            gate_sync  <= '0;
            latch_sync <= '0;
            clear_sync <= '0;
            sig_d      <= 1'b0;
            latch_d    <= 1'b0;
            clear_d    <= 1'b0;
            edge_p     <= 1'b0;
            latch_p    <= 1'b0;
            clear_p    <= 1'b0;
        end else begin
            sig_sync   <= {sig_sync[SYNC_STAGES-2:0], sig_in};
            gate_sync  <= {gate_sync[SYNC_STAGES-2:0], count_en};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_en};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], clear};
            sig_d      <= sig_sync[SYNC_STAGES-1];
            latch_d    <= latch_sync[SYNC_STAGES-1];
            clear_d    <= clear_sync[SYNC_STAGES-1];
            edge_p     <= sig_sync[SYNC_STAGES-1] & ~sig_d;
            latch_p    <= latch_sync[SYNC_STAGES-1] & ~latch_d;
            clear_p    <= clear_sync[SYNC_STAGES-1] & ~clear_d;
        end
    end

    assign gate = gate_sync[SYNC_STAGES-1];

    always_comb begin
        count_inc = bcd_inc(count);
        inc_req   = (state == S_COUNT) && gate && edge_p;
    end

    // clear_p takes priority over every transition, including a simultaneous latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            freq_bcd   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (clear_p) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (gate) state <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (!gate) begin
                            state <= S_DONE;
                        end else if (inc_req) begin
`ifdef FREQ_OVF_SATURATE_EN
                            if (count != {DIGITS{4'h9}}) count <= count_inc;
`else
                            count <= count_inc;
`endif
                        end
                    end
                    S_DONE: begin
                        if (latch_p) begin
                            freq_bcd   <= count;
                            freq_valid <= 1'b1;
                            state      <= S_LATCHED;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef FREQ_OVF_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clear_p) begin
            ovf <= 1'b0;
        end else if (inc_req && (count == {DIGITS{4'h9}})) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_freq_counter_latch.sv
// Bench for freq_counter_latch: an 8-decade and a 2-decade instance share one randomized stimulus.
// A pulse-count model predicts the published display, valid pulses and overflow flag.
module tb_freq_counter_latch;

    localparam int SET = 8;
    localparam int P_IDLE = 0, P_DONE = 1, P_LATCHED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sig_in = 1'b0;
    logic        count_en = 1'b0;
    logic        latch_en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] freq_a;
    logic        fv_a;
    logic        ovf_a;
    logic [7:0]  freq_b;
    logic        fv_b;
    logic        ovf_b;

    freq_counter_latch #(.DIGITS(8), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .count_en(count_en),
        .latch_en(latch_en), .clear(clear),
        .freq_bcd(freq_a), .freq_valid(fv_a), .ovf(ovf_a)
    );

    freq_counter_latch #(.DIGITS(2), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .count_en(count_en),
        .latch_en(latch_en), .clear(clear),
        .freq_bcd(freq_b), .freq_valid(fv_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          count_a = 0;
    int          count_b = 0;
    logic        exp_ovf_b = 1'b0;
    int          phase = P_IDLE;
    logic [31:0] exp_a = '0;
    logic [7:0]  exp_b = '0;
    int          req_a = 0, seen_a = 0;
    int          req_b = 0, seen_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic monitor();
        forever begin
            @(posedge clk);
            #2;
            if (fv_a) begin
                check("valid_a_unexpected", (seen_a < req_a), 1'b1);
                check("freq_a_on_valid", freq_a, exp_a);
                seen_a++;
            end else if (seen_a == req_a) begin
                check("freq_a_hold", freq_a, exp_a);
            end
            if (fv_b) begin
                check("valid_b_unexpected", (seen_b < req_b), 1'b1);
                check("freq_b_on_valid", freq_b, exp_b);
                seen_b++;
            end else if (seen_b == req_b) begin
                check("freq_b_hold", freq_b, exp_b);
            end
            check("ovf_a_never", ovf_a, 1'b0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            sig_in = 1'b1;
            tick(2);
            sig_in = 1'b0;
            tick(2);
        end
    endtask

    task automatic model_add(input int n);
        count_a = (count_a + n) % 100000000;
`ifdef FREQ_OVF_SATURATE_EN
        if (count_b + n > 99) begin
            count_b   = 99;
            exp_ovf_b = 1'b1;
        end else begin
            count_b = count_b + n;
        end
`else
        count_b = (count_b + n) % 100;
`endif
    endtask

    task automatic window(input int nb, input int ni, input int na);
        pulse(nb);
        count_en = 1'b1;
        tick(SET);
        pulse(ni);
        tick(SET);
        count_en = 1'b0;
        tick(SET);
        pulse(na);
        tick(SET);
        if (phase == P_IDLE) begin
            model_add(ni);
            phase = P_DONE;
        end
        check("ovf_b_window", ovf_b, exp_ovf_b);
    endtask

    task automatic do_latch();
        int va, vb, e;
        logic [31:0] tb;
        va = seen_a;
        vb = seen_b;
        e  = 0;
        latch_en = 1'b1;
        if (phase == P_DONE) begin
            exp_a = to_bcd(count_a);
            tb    = to_bcd(count_b);
            exp_b = tb[7:0];
            req_a++;
            req_b++;
            phase = P_LATCHED;
            e = 1;
        end
        tick(SET);
        latch_en = 1'b0;
        tick(SET);
        check("valid_a_pulses", seen_a - va, e);
        check("valid_b_pulses", seen_b - vb, e);
    endtask

    task automatic do_clear(input logic with_latch);
        int va, vb;
        va = seen_a;
        vb = seen_b;
        clear    = 1'b1;
        latch_en = with_latch;
        count_a = 0;
        count_b = 0;
        exp_ovf_b = 1'b0;
        phase = P_IDLE;
        tick(SET);
        clear    = 1'b0;
        latch_en = 1'b0;
        tick(SET);
        check("valid_a_on_clear", seen_a - va, 0);
        check("valid_b_on_clear", seen_b - vb, 0);
        check("ovf_b_clear", ovf_b, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        fork
            monitor();
        join_none
        tick(3);
        check("rst_freq_a", freq_a, 32'h0);
        check("rst_valid_a", fv_a, 1'b0);
        check("rst_ovf_a", ovf_a, 1'b0);
        check("rst_freq_b", freq_b, 8'h0);
        check("rst_ovf_b", ovf_b, 1'b0);
        rst_n = 1'b1;
        tick(SET);

        // pulses outside the gate are ignored
        window(50, 7, 50);
        do_latch();
        check("s033_model", exp_a, 32'h00000007);
        check("s033_freq", freq_a, 32'h00000007);

        do_clear(1'b0);
        window(0, 1234, 0);
        do_latch();
        check("s032_freq", freq_a, 32'h00001234);

        do_clear(1'b0);
        window(0, 105, 0);
        do_latch();
        check("s034_freq_a", freq_a, 32'h00000105);
`ifdef FREQ_OVF_SATURATE_EN
        check("s034_freq_b", freq_b, 8'h99);
        check("s034_ovf_b", ovf_b, 1'b1);
`else
        check("s034_freq_b", freq_b, 8'h05);
        check("s034_ovf_b", ovf_b, 1'b0);
`endif

        do_clear(1'b0);
        window(0, 42, 0);
        do_latch();
        do_clear(1'b0);
        check("s035_persist", freq_a, 32'h00000042);
        window(0, 3, 0);
        do_latch();
        check("s035_new", freq_a, 32'h00000003);

        // latch ignored while LATCHED, and clear beats a same-cycle latch
        do_latch();
        do_clear(1'b0);
        window(0, 5, 0);
        do_clear(1'b1);
        check("s036_unchanged", freq_a, 32'h00000003);
        window(0, 6, 0);
        do_latch();
        check("s036_count_zeroed", freq_a, 32'h00000006);

        // reset mid-window, gate held high through reset release
        do_clear(1'b0);
        count_en = 1'b1;
        tick(SET);
        pulse(500);
        rst_n = 1'b0;
        exp_a = '0;
        exp_b = '0;
        count_a = 0;
        count_b = 0;
        exp_ovf_b = 1'b0;
        phase = P_IDLE;
        tick(3);
        check("s037_rst_freq", freq_a, 32'h0);
        rst_n = 1'b1;
        tick(SET);
        pulse(9);
        model_add(9);
        tick(SET);
        count_en = 1'b0;
        tick(SET);
        phase = P_DONE;
        do_latch();
        check("s037_freq", freq_a, 32'h00000009);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) != 0) do_clear(1'b0);
            window($urandom_range(0, 20), $urandom_range(0, 300), $urandom_range(0, 20));
            if ($urandom_range(0, 4) != 0) do_latch();
        end

        tick(SET);
        check("final_no_pending_a", req_a - seen_a, 0);
        check("final_no_pending_b", req_b - seen_b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
